// File: rtl/jk_reg_bank.sv
// ---------------------------------------------------------------------------
// jk_reg_bank
//
// Purpose:
//   A bank of WIDTH positive-edge JK flip-flops. Each edge can apply per-bit
//   J/K control, do a parallel load, or count up or down. Every mode is
//   expressed as an effective per-bit (J, K) pair, and one JK cell equation
//   then produces the next state. Counting drives J=K=1 on the bits that a
//   ripple-free toggle chain enables. No adder is used.
//
// Ports:
//   clk      in   1      rising-edge clock for all state
//   reset    in   1      synchronous, active-high; forces Q=RESET_VAL, changed=0
//   en       in   1      update enable; 0 holds Q and clears changed
//   mode     in   2      00 JK, 01 load, 10 count up, 11 count down
//   J, K     in   WIDTH  per-bit JK control (mode 00 only)
//   D        in   WIDTH  parallel load data (mode 01 only)
//   Q        out  WIDTH  registered bank state
//   Qbar     out  WIDTH  ~Q (combinational)
//   changed  out  WIDTH  registered mask of bits that flipped on the last edge
//   tc       out  1      terminal count: all-ones in up mode, zero in down mode
// ---------------------------------------------------------------------------
module jk_reg_bank #(
  parameter int              WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] J,
  input  logic [WIDTH-1:0] K,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] Qbar,
  output logic [WIDTH-1:0] changed,
  output logic             tc
);

  typedef enum logic [1:0] {
    MODE_JK   = 2'b00,
    MODE_LOAD = 2'b01,
    MODE_UP   = 2'b10,
    MODE_DOWN = 2'b11
  } mode_e;

  mode_e            mode_s;
  logic [WIDTH-1:0] q_q,       q_d;
  logic [WIDTH-1:0] changed_q, changed_d;
  logic [WIDTH-1:0] up_tgl_s;   // bit i toggles on count-up
  logic [WIDTH-1:0] dn_tgl_s;   // bit i toggles on count-down
  logic [WIDTH-1:0] j_eff_s;
  logic [WIDTH-1:0] k_eff_s;
  logic [WIDTH-1:0] jk_next_s;
  logic             ones_run_s;
  logic             zeros_run_s;
  logic             tc_s;

  assign mode_s = mode_e'(mode);

  // Toggle chain: a bit toggles when every lower bit is 1 (up) or 0 (down).
  always_comb begin
    up_tgl_s    = '0;
    dn_tgl_s    = '0;
    ones_run_s  = 1'b1;
    zeros_run_s = 1'b1;
    for (int i = 0; i < WIDTH; i++) begin
      up_tgl_s[i] = ones_run_s;
      dn_tgl_s[i] = zeros_run_s;
      ones_run_s  = ones_run_s & q_q[i];
      zeros_run_s = zeros_run_s & ~q_q[i];
    end
  end

  // Map the selected mode onto the effective per-bit J/K inputs.
  always_comb begin
    j_eff_s = '0;
    k_eff_s = '0;
    case (mode_s)
      MODE_JK: begin
        j_eff_s = J;
        k_eff_s = K;
      end
      MODE_LOAD: begin
        // A 1 in D sets the bit (J=1,K=0) and a 0 clears it (J=0,K=1).
        j_eff_s = D;
        k_eff_s = ~D;
      end
      MODE_UP: begin
        j_eff_s = up_tgl_s;
        k_eff_s = up_tgl_s;
      end
      MODE_DOWN: begin
        j_eff_s = dn_tgl_s;
        k_eff_s = dn_tgl_s;
      end
      default: begin
        j_eff_s = '0;
        k_eff_s = '0;
      end
    endcase
  end

  // JK characteristic equation Q+ = J&~Q | ~K&Q, then gate with enable.
  always_comb begin
    jk_next_s = (j_eff_s & ~q_q) | (~k_eff_s & q_q);
    if (en) begin
      q_d = jk_next_s;
    end else begin
      q_d = q_q;
    end
    changed_d = q_d ^ q_q;
  end

  // State and change-mask registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      q_q       <= RESET_VAL;
      changed_q <= '0;
    end else begin
      q_q       <= q_d;
      changed_q <= changed_d;
    end
  end

  // Terminal count follows the current mode and Q. It does not depend on en.
  always_comb begin
    tc_s = 1'b0;
    case (mode_s)
      MODE_UP:   tc_s = &q_q;
      MODE_DOWN: tc_s = ~|q_q;
      MODE_JK:   tc_s = 1'b0;
      MODE_LOAD: tc_s = 1'b0;
      default:   tc_s = 1'b0;
    endcase
  end

  assign Q       = q_q;
  assign Qbar    = ~q_q;
  assign changed = changed_q;
  assign tc      = tc_s;

endmodule

// File: tb/tb_jk_reg_bank.sv
// ---------------------------------------------------------------------------
// tb_jk_reg_bank
//   Self-checking bench for jk_reg_bank with WIDTH=4 and RESET_VAL=4'h5.
//   Directed scenarios are followed by a randomized run. Expected values come
//   from a behavioural model that works in integer arithmetic.
// ---------------------------------------------------------------------------
module tb_jk_reg_bank;

  localparam int         W  = 4;
  localparam logic [3:0] RV = 4'h5;

  logic       clk = 1'b0;
  logic       reset;
  logic       en;
  logic [1:0] mode;
  logic [3:0] J, K, D;
  logic [3:0] Q, Qbar, changed;
  logic       tc;

  int checks   = 0;
  int failures = 0;

  logic [3:0] m_q;
  logic [3:0] m_changed;

  jk_reg_bank #(.WIDTH(W), .RESET_VAL(RV)) dut (
    .clk(clk), .reset(reset), .en(en), .mode(mode),
    .J(J), .K(K), .D(D),
    .Q(Q), .Qbar(Qbar), .changed(changed), .tc(tc)
  );

  always #5 clk = ~clk;

  // Reference next state using plain arithmetic for the count modes.
  function automatic logic [3:0] model_next(input logic [3:0] q, input logic e,
                                            input logic [1:0] m, input logic [3:0] j,
                                            input logic [3:0] k, input logic [3:0] d);
    logic [3:0] r;
    int v;
    r = q;
    if (e) begin
      case (m)
        2'd0: begin
          for (int i = 0; i < 4; i++) begin
            if (j[i] && k[i])       r[i] = ~q[i];
            else if (j[i])          r[i] = 1'b1;
            else if (k[i])          r[i] = 1'b0;
            else                    r[i] = q[i];
          end
        end
        2'd1: r = d;
        2'd2: begin v = (int'(q) + 1) % 16;  r = v[3:0]; end
        default: begin v = (int'(q) + 15) % 16; r = v[3:0]; end
      endcase
    end
    return r;
  endfunction

  function automatic logic model_tc(input logic [3:0] q, input logic [1:0] m);
    return (m == 2'd2 && q == 4'hF) || (m == 2'd3 && q == 4'h0);
  endfunction

  // Apply inputs, clock one edge, sample 1 time unit later and update the model.
  task automatic step(input logic r, input logic e, input logic [1:0] m,
                      input logic [3:0] j, input logic [3:0] k, input logic [3:0] d);
    logic [3:0] nq;
    reset = r; en = e; mode = m; J = j; K = k; D = d;
    if (r) nq = RV;
    else   nq = model_next(m_q, e, m, j, k, d);
    m_changed = r ? 4'h0 : (nq ^ m_q);
    @(posedge clk);
    #1;
    m_q = nq;
  endtask

  task automatic test_reset();
    for (int n = 0; n < 2; n++) begin
      step(1'b1, 1'b1, 2'b10, 4'hF, 4'hF, 4'hF);
      checks++;
      if (Q !== 4'h5) begin failures++; $display("FAIL reset_q edge%0d: got %h want 5", n, Q); end
      checks++;
      if (Qbar !== 4'hA) begin failures++; $display("FAIL reset_qbar edge%0d: got %h want A", n, Qbar); end
      checks++;
      if (changed !== 4'h0) begin failures++; $display("FAIL reset_changed edge%0d: got %h want 0", n, changed); end
    end
  endtask

  task automatic test_jk();
    step(1'b0, 1'b1, 2'b01, 4'h0, 4'h0, 4'h5);
    step(1'b0, 1'b1, 2'b00, 4'b1100, 4'b1010, 4'h0);
    checks++;
    if (Q !== 4'hD) begin failures++; $display("FAIL jk_q: got %h want D", Q); end
    checks++;
    if (changed !== 4'h8) begin failures++; $display("FAIL jk_changed: got %h want 8", changed); end
    checks++;
    if (tc !== 1'b0) begin failures++; $display("FAIL jk_tc: got %b want 0", tc); end
  endtask

  task automatic test_count_up();
    logic [3:0] eq [3];
    logic [3:0] ec [3];
    logic       et [3];
    eq = '{4'hF, 4'h0, 4'h1};
    ec = '{4'h1, 4'hF, 4'h1};
    et = '{1'b1, 1'b0, 1'b0};
    step(1'b0, 1'b1, 2'b01, 4'h0, 4'h0, 4'hE);
    for (int n = 0; n < 3; n++) begin
      step(1'b0, 1'b1, 2'b10, 4'h3, 4'h6, 4'h2);
      checks++;
      if (Q !== eq[n]) begin failures++; $display("FAIL up_q%0d: got %h want %h", n, Q, eq[n]); end
      checks++;
      if (changed !== ec[n]) begin failures++; $display("FAIL up_changed%0d: got %h want %h", n, changed, ec[n]); end
      checks++;
      if (tc !== et[n]) begin failures++; $display("FAIL up_tc%0d: got %b want %b", n, tc, et[n]); end
    end
  endtask

  task automatic test_count_down();
    logic [3:0] eq [3];
    logic [3:0] ec [3];
    logic       et [3];
    eq = '{4'h0, 4'hF, 4'hE};
    ec = '{4'h1, 4'hF, 4'h1};
    et = '{1'b1, 1'b0, 1'b0};
    step(1'b0, 1'b1, 2'b01, 4'h0, 4'h0, 4'h1);
    for (int n = 0; n < 3; n++) begin
      step(1'b0, 1'b1, 2'b11, 4'hC, 4'h9, 4'h7);
      checks++;
      if (Q !== eq[n]) begin failures++; $display("FAIL down_q%0d: got %h want %h", n, Q, eq[n]); end
      checks++;
      if (changed !== ec[n]) begin failures++; $display("FAIL down_changed%0d: got %h want %h", n, changed, ec[n]); end
      checks++;
      if (tc !== et[n]) begin failures++; $display("FAIL down_tc%0d: got %b want %b", n, tc, et[n]); end
    end
  endtask

  task automatic test_load_enable();
    step(1'b0, 1'b1, 2'b01, 4'h0, 4'h0, 4'h3);
    for (int n = 0; n < 2; n++) begin
      step(1'b0, 1'b0, 2'b01, 4'hF, 4'hF, 4'h9);
      checks++;
      if (Q !== 4'h3) begin failures++; $display("FAIL hold_q%0d: got %h want 3", n, Q); end
      checks++;
      if (changed !== 4'h0) begin failures++; $display("FAIL hold_changed%0d: got %h want 0", n, changed); end
    end
    step(1'b0, 1'b1, 2'b01, 4'hF, 4'hF, 4'h9);
    checks++;
    if (Q !== 4'h9) begin failures++; $display("FAIL load_q: got %h want 9", Q); end
    checks++;
    if (changed !== 4'hA) begin failures++; $display("FAIL load_changed: got %h want A", changed); end
  endtask

  task automatic test_reset_mid_count();
    step(1'b1, 1'b0, 2'b00, 4'h0, 4'h0, 4'h0);
    step(1'b0, 1'b1, 2'b10, 4'h0, 4'h0, 4'h0);
    step(1'b0, 1'b1, 2'b10, 4'h0, 4'h0, 4'h0);
    checks++;
    if (Q !== 4'h7) begin failures++; $display("FAIL midrst_pre_q: got %h want 7", Q); end
    step(1'b1, 1'b1, 2'b10, 4'h0, 4'h0, 4'h0);
    checks++;
    if (Q !== 4'h5) begin failures++; $display("FAIL midrst_q: got %h want 5", Q); end
    checks++;
    if (changed !== 4'h0) begin failures++; $display("FAIL midrst_changed: got %h want 0", changed); end
    step(1'b0, 1'b1, 2'b10, 4'h0, 4'h0, 4'h0);
    checks++;
    if (Q !== 4'h6) begin failures++; $display("FAIL midrst_resume_q: got %h want 6", Q); end
    checks++;
    if (changed !== 4'h3) begin failures++; $display("FAIL midrst_resume_changed: got %h want 3", changed); end
  endtask

  task automatic test_random();
    logic       r, e;
    logic [1:0] m;
    logic [3:0] j, k, d;
    for (int n = 0; n < 400; n++) begin
      r = ($urandom_range(0, 15) == 0);
      e = ($urandom_range(0, 3) != 0);
      m = 2'($urandom_range(0, 3));
      j = 4'($urandom);
      k = 4'($urandom);
      d = 4'($urandom);
      step(r, e, m, j, k, d);
      checks++;
      if (Q !== m_q) begin failures++; $display("FAIL rand_q cycle%0d: got %h want %h", n, Q, m_q); end
      checks++;
      if (Qbar !== ~m_q) begin failures++; $display("FAIL rand_qbar cycle%0d: got %h want %h", n, Qbar, ~m_q); end
      checks++;
      if (changed !== m_changed) begin failures++; $display("FAIL rand_changed cycle%0d: got %h want %h", n, changed, m_changed); end
      checks++;
      if (tc !== model_tc(m_q, m)) begin failures++; $display("FAIL rand_tc cycle%0d: got %b want %b", n, tc, model_tc(m_q, m)); end
    end
  endtask

  initial begin
    reset = 1'b1; en = 1'b0; mode = 2'b00; J = 4'h0; K = 4'h0; D = 4'h0;
    m_q = RV; m_changed = 4'h0;
    test_reset();
    test_jk();
    test_count_up();
    test_count_down();
    test_load_enable();
    test_reset_mid_count();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
